lcd_bus_responder: RTL and testbench

//  HD44780-style LCD target. Sits on the far end of the CPU's data/rs/rw/en bus.

---
 rtl/lcd_bus_responder.sv | 189 ++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style LCD target on the CPU data/rs/rw/en bus.
// Holds a 2x16 DDRAM, the address counter, display-on bit and busy counter,
// and exposes a combinational scan port for display logic.
// Optional feature: define LCD_SHIFT_EN to enable the cursor/display shift command.
`timescale 1ns/1ps
module lcd_bus_responder #(
  parameter int unsigned BUSY_CYCLES  = 37,
  parameter int unsigned CLEAR_CYCLES = 152
) (
  input  logic       clk,
  input  logic       power,
  input  logic [7:0] lcd_data,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic [6:0] cursor,
  output logic       disp_on,
  input  logic [4:0] scan_idx,
  output logic [7:0] scan_char,
  output logic       overrun
);

  localparam int unsigned MAX_CYCLES = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned CELLS      = 32;
  localparam logic [7:0]  BLANK      = 8'h20;

  logic [7:0]       ddram [CELLS];
  logic             en_q;
  logic             id_q;
  logic             commit;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_n;
  logic [6:0]       cursor_n;
  logic             disp_n;
  logic             id_n;
  logic             ovr_n;
  logic             wr_en;
  logic             clr;
  logic [3:0]       ofs_q;
  logic [4:0]       cur_idx;
  logic [4:0]       scan_cell;
  logic [3:0]       scan_col;
`ifdef LCD_SHIFT_EN
  logic [3:0]       ofs_n;
`endif

  // Address counter step with line wrap: 0x0F<->0x40, 0x4F<->0x00.
  function automatic logic [6:0] step(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      if (a == 7'h0F)      r = 7'h40;
      else if (a == 7'h4F) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h4F;
      else if (a == 7'h40) r = 7'h0F;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  assign busy      = (cnt_q != '0);
  assign commit    = en_q & ~lcd_en;
  assign cur_idx   = {cursor[6], cursor[3:0]};
  assign scan_col  = scan_idx[3:0] + ofs_q;
  assign scan_cell = {scan_idx[4], scan_col};

  // Next-state decode of the transfer committed on the en falling edge.
  always_comb begin
    cursor_n = cursor;
    disp_n   = disp_on;
    id_n     = id_q;
    ovr_n    = overrun;
    wr_en    = 1'b0;
    clr      = 1'b0;
    cnt_n    = busy ? (cnt_q - CNT_W'(1)) : cnt_q;
`ifdef LCD_SHIFT_EN
    ofs_n    = ofs_q;
`endif
    if (commit) begin
      if (!lcd_rw) begin
        if (busy) begin
          ovr_n = 1'b1;
        end else if (lcd_rs) begin
          wr_en    = 1'b1;
          cursor_n = step(cursor, id_q);
          cnt_n    = CNT_W'(BUSY_CYCLES);
        end else begin
          casez (lcd_data)
            8'b1???????: begin
              cursor_n = ((lcd_data[6:4] == 3'b000) || (lcd_data[6:4] == 3'b100)) ?
                         lcd_data[6:0] : 7'h00;
              cnt_n    = CNT_W'(BUSY_CYCLES);
            end
            8'b01??????,
            8'b001?????: cnt_n = CNT_W'(BUSY_CYCLES);
            8'b0001????: begin
`ifdef LCD_SHIFT_EN
              if (!lcd_data[3]) cursor_n = step(cursor, lcd_data[2]);
              else              ofs_n    = lcd_data[2] ? (ofs_q - 4'd1) : (ofs_q + 4'd1);
`endif
              cnt_n = CNT_W'(BUSY_CYCLES);
            end
            8'b00001???: begin
              disp_n = lcd_data[2];
              cnt_n  = CNT_W'(BUSY_CYCLES);
            end
            8'b000001??: begin
              id_n  = lcd_data[1];
              cnt_n = CNT_W'(BUSY_CYCLES);
            end
            8'b0000001?: begin
              cursor_n = 7'h00;
`ifdef LCD_SHIFT_EN
              ofs_n    = 4'd0;
`endif
              cnt_n    = CNT_W'(CLEAR_CYCLES);
            end
            8'b00000001: begin
              clr      = 1'b1;
              cursor_n = 7'h00;
              id_n     = 1'b1;
              cnt_n    = CNT_W'(CLEAR_CYCLES);
            end
            default: ;
          endcase
        end
      end else if (lcd_rs && !busy) begin
        cursor_n = step(cursor, id_q);
      end
    end
  end

  // Control registers: edge detector, cursor, mode bits, busy counter.
  always_ff @(posedge clk or posedge power) begin
    if (power) begin
      en_q    <= 1'b0;
      cursor  <= 7'h00;
      disp_on <= 1'b0;
      id_q    <= 1'b1;
      overrun <= 1'b0;
      cnt_q   <= '0;
    end else begin
      en_q    <= lcd_en;
      cursor  <= cursor_n;
      disp_on <= disp_n;
      id_q    <= id_n;
      overrun <= ovr_n;
      cnt_q   <= cnt_n;
    end
  end

`ifdef LCD_SHIFT_EN
  // Display shift offset applied to the scan column.
  always_ff @(posedge clk or posedge power) begin
    if (power) ofs_q <= 4'd0;
    else       ofs_q <= ofs_n;
  end
`else
  assign ofs_q = 4'd0;
`endif

  // DDRAM: bulk blank on reset/clear, single-cell data writes.
  always_ff @(posedge clk or posedge power) begin
    if (power) begin
      for (int unsigned i = 0; i < CELLS; i++) ddram[i] <= BLANK;
    end else if (clr) begin
      for (int unsigned i = 0; i < CELLS; i++) ddram[i] <= BLANK;
    end else if (wr_en) begin
      ddram[cur_idx] <= lcd_data;
    end
  end

  // Read-back bus: status or DDRAM while en is high on a read.
  always_comb begin
    rd_data = 8'h00;
    if (lcd_en && lcd_rw) rd_data = lcd_rs ? ddram[cur_idx] : {busy, cursor};
  end

  // Scan port: blank when the display is off.
  always_comb begin
    scan_char = BLANK;
    if (disp_on) scan_char = ddram[scan_cell];
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: directed table, hand sequences and random traffic
// against a behavioural LCD model (linear 32-cell screen, busy deadline).
`timescale 1ns/1ps
module tb_lcd_bus_responder;

  localparam int BUSY_N  = 37;
  localparam int CLEAR_N = 152;

  logic       clk;
  logic       power;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] rd_data;
  logic       busy;
  logic [6:0] cursor;
  logic       disp_on;
  logic [4:0] scan_idx;
  logic [7:0] scan_char;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [7:0] m_mem [32];
  int m_cur, m_id, m_disp, m_ovr, m_ofs, m_now, m_until;

  lcd_bus_responder dut (
    .clk(clk), .power(power), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .rd_data(rd_data), .busy(busy), .cursor(cursor), .disp_on(disp_on),
    .scan_idx(scan_idx), .scan_char(scan_char), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pos_of(input int a);
    return ((a >= 64) ? 16 : 0) + (a & 15);
  endfunction

  function automatic int addr_of(input int p);
    return ((p >= 16) ? 64 : 0) + (p % 16);
  endfunction

  function automatic int m_step(input int a, input int up);
    return addr_of((pos_of(a) + (up != 0 ? 1 : 31)) % 32);
  endfunction

  function automatic int m_busy();
    return (m_now < m_until) ? 1 : 0;
  endfunction

  function automatic int m_scan(input int idx);
    if (m_disp == 0) return 8'h20;
    return int'(m_mem[(idx / 16) * 16 + (((idx % 16) + m_ofs) % 16)]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_cur = 0; m_id = 1; m_disp = 0; m_ovr = 0; m_ofs = 0; m_until = m_now;
  endtask

  task automatic model_commit(input logic rs, input logic rw, input logic [7:0] d, input int was_busy);
    int a;
    if (!rw) begin
      if (was_busy != 0) m_ovr = 1;
      else if (rs) begin
        m_mem[pos_of(m_cur)] = d;
        m_cur = m_step(m_cur, m_id);
        m_until = m_now + BUSY_N;
      end else if (d == 8'h00) begin
      end else if (d[7]) begin
        a = int'(d & 8'h7F);
        m_cur = (a < 16 || (a >= 64 && a < 80)) ? a : 0;
        m_until = m_now + BUSY_N;
      end else if (d[6] || d[5]) begin
        m_until = m_now + BUSY_N;
      end else if (d[4]) begin
`ifdef LCD_SHIFT_EN
        if (!d[3]) m_cur = m_step(m_cur, int'(d[2]));
        else m_ofs = d[2] ? (m_ofs + 15) % 16 : (m_ofs + 1) % 16;
`endif
        m_until = m_now + BUSY_N;
      end else if (d[3]) begin
        m_disp = int'(d[2]);
        m_until = m_now + BUSY_N;
      end else if (d[2]) begin
        m_id = int'(d[1]);
        m_until = m_now + BUSY_N;
      end else if (d[1]) begin
        m_cur = 0; m_ofs = 0;
        m_until = m_now + CLEAR_N;
      end else begin
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_cur = 0; m_id = 1;
        m_until = m_now + CLEAR_N;
      end
    end else if (rs && was_busy == 0) begin
      m_cur = m_step(m_cur, m_id);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_now++;
    @(negedge clk);
  endtask

  // One bus transfer; optional junk cycle proves only commit-cycle values count.
  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, input bit junk,
                      output logic [7:0] rd);
    int was_busy;
    int exp;
    if (junk && !rw) begin
      lcd_rw = 1'b0; lcd_rs = 1'($urandom_range(0, 1)); lcd_data = 8'($urandom); lcd_en = 1'b1;
      tick();
    end
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    #1;
    rd = rd_data;
    if (!rw) exp = 0;
    else if (rs) exp = int'(m_mem[pos_of(m_cur)]);
    else exp = m_busy() * 128 + m_cur;
    chk("rd_data_en_high", int'(rd), exp);
    tick();
    lcd_en = 1'b0;
    #1;
    chk("rd_data_en_low", int'(rd_data), 0);
    was_busy = m_busy();
    tick();
    model_commit(rs, rw, d, was_busy);
  endtask

  task automatic post_chk();
    chk("cursor", int'(cursor), m_cur);
    chk("busy", int'(busy), m_busy());
    chk("overrun", int'(overrun), m_ovr);
    chk("disp_on", int'(disp_on), m_disp);
  endtask

  task automatic scan_chk(input int idx);
    scan_idx = 5'(idx);
    #1;
    chk("scan_char", int'(scan_char), m_scan(idx));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 500) begin tick(); n++; end
    chk("idle_wait", int'(busy), 0);
  endtask

  function automatic logic [7:0] rand_cmd();
    int k;
    logic [7:0] r;
    k = $urandom_range(0, 19);
    r = 8'($urandom);
    if (k < 6)       return 8'h80 | r;
    else if (k < 8)  return 8'h20 | (r & 8'h1F);
    else if (k < 11) return 8'h10 | (r & 8'h0F);
    else if (k < 13) return 8'h0C | (r & 8'h03);
    else if (k < 15) return 8'h04 | (r & 8'h03);
    else if (k < 16) return 8'h08 | (r & 8'h03);
    else if (k < 17) return 8'h02 | (r & 8'h01);
    else if (k < 18) return 8'h01;
    else             return 8'h00;
  endfunction

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic [6:0] cur;
    int         blen;
    int         sidx;
    logic [7:0] sch;
  } vec_t;

  initial begin
    vec_t tbl [17];
    logic [7:0] rd;
    int c, n, r;

    tbl[0]  = '{1'b0, 8'h0C, 7'h00, 37,  0, 8'h20};
    tbl[1]  = '{1'b1, 8'h48, 7'h01, 37,  0, 8'h48};
    tbl[2]  = '{1'b1, 8'h49, 7'h02, 37,  1, 8'h49};
    tbl[3]  = '{1'b0, 8'h8F, 7'h0F, 37, 15, 8'h20};
    tbl[4]  = '{1'b1, 8'h41, 7'h40, 37, 15, 8'h41};
    tbl[5]  = '{1'b0, 8'h04, 7'h40, 37, 15, 8'h41};
    tbl[6]  = '{1'b0, 8'hC0, 7'h40, 37, 16, 8'h20};
    tbl[7]  = '{1'b1, 8'h42, 7'h0F, 37, 16, 8'h42};
    tbl[8]  = '{1'b0, 8'h80, 7'h00, 37, 15, 8'h41};
    tbl[9]  = '{1'b1, 8'h43, 7'h4F, 37,  0, 8'h43};
    tbl[10] = '{1'b0, 8'h06, 7'h4F, 37,  0, 8'h43};
    tbl[11] = '{1'b1, 8'h44, 7'h00, 37, 31, 8'h44};
    tbl[12] = '{1'b0, 8'h95, 7'h00, 37, 31, 8'h44};
    tbl[13] = '{1'b0, 8'h02, 7'h00, 152, 1, 8'h49};
    tbl[14] = '{1'b0, 8'h00, 7'h00,  0,  1, 8'h49};
    tbl[15] = '{1'b0, 8'h08, 7'h00, 37,  1, 8'h20};
    tbl[16] = '{1'b0, 8'h0C, 7'h00, 37,  1, 8'h49};

    power = 1'b1; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h00; scan_idx = 5'd0;
    m_now = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_cursor", int'(cursor), 0);
    chk("reset_disp_on", int'(disp_on), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_scan", int'(scan_char), 8'h20);
    @(negedge clk);
    power = 1'b0;
    model_reset();

    // Display on, then every cell blank.
    xfer(1'b0, 1'b0, 8'h0C, 1'b0, rd);
    wait_idle();
    for (int i = 0; i < 32; i++) begin
      scan_idx = 5'(i);
      #1;
      chk("blank_scan", int'(scan_char), 8'h20);
    end

    // Directed table: cursor movement, wrap, busy length, scan contents.
    for (int i = 0; i < 17; i++) begin
      xfer(tbl[i].rs, 1'b0, tbl[i].d, 1'b0, rd);
      chk($sformatf("tbl%0d_cursor", i), int'(cursor), int'(tbl[i].cur));
      n = 0;
      while (busy === 1'b1 && n < 400) begin tick(); n++; end
      chk($sformatf("tbl%0d_busy_len", i), n, tbl[i].blen);
      scan_idx = 5'(tbl[i].sidx);
      #1;
      chk($sformatf("tbl%0d_scan", i), int'(scan_char), int'(tbl[i].sch));
    end

    // Clear, then a write while busy is dropped; status stays 0x80 for 152 clk.
    xfer(1'b0, 1'b0, 8'h01, 1'b0, rd);
    c = m_now;
    repeat (8) tick();
    xfer(1'b1, 1'b0, 8'h55, 1'b0, rd);
    chk("overrun_set", int'(overrun), 1);
    xfer(1'b0, 1'b1, 8'h00, 1'b0, rd);
    chk("clear_status", int'(rd), 8'h80);
    while (m_now < c + CLEAR_N + 4) begin
      xfer(1'b0, 1'b1, 8'h00, 1'b0, rd);
      post_chk();
    end
    chk("clear_done_busy", int'(busy), 0);
    for (int i = 0; i < 32; i++) begin
      scan_idx = 5'(i);
      #1;
      chk("cleared_scan", int'(scan_char), 8'h20);
    end

    // Address set, status read, data read with step, async reset mid-busy.
    xfer(1'b0, 1'b0, 8'h85, 1'b0, rd); wait_idle();
    xfer(1'b1, 1'b0, 8'h5A, 1'b0, rd); wait_idle();
    xfer(1'b0, 1'b0, 8'h85, 1'b0, rd); wait_idle();
    xfer(1'b0, 1'b1, 8'h00, 1'b0, rd);
    chk("status_addr5", int'(rd), 8'h05);
    xfer(1'b1, 1'b1, 8'h00, 1'b0, rd);
    chk("data_read5", int'(rd), 8'h5A);
    chk("cursor_after_read", int'(cursor), 8'h06);
    xfer(1'b0, 1'b0, 8'h01, 1'b0, rd);
    repeat (20) tick();
    chk("busy_before_power", int'(busy), 1);
    #2;
    power = 1'b1;
    #1;
    chk("power_busy", int'(busy), 0);
    chk("power_cursor", int'(cursor), 0);
    chk("power_overrun", int'(overrun), 0);
    tick();
    power = 1'b0;
    model_reset();

    // Shift command after writing 'A' at 0x01.
    xfer(1'b0, 1'b0, 8'h0C, 1'b0, rd); wait_idle();
    xfer(1'b0, 1'b0, 8'h81, 1'b0, rd); wait_idle();
    xfer(1'b1, 1'b0, 8'h41, 1'b0, rd); wait_idle();
    xfer(1'b0, 1'b0, 8'h18, 1'b0, rd); wait_idle();
    scan_idx = 5'd0; #1;
`ifdef LCD_SHIFT_EN
    chk("shift_scan0", int'(scan_char), 8'h41);
`else
    chk("noshift_scan0", int'(scan_char), 8'h20);
    scan_idx = 5'd1; #1;
    chk("noshift_scan1", int'(scan_char), 8'h41);
`endif
    scan_chk(0);
    scan_chk(1);
    post_chk();

    // Random traffic against the model.
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      xfer(1'b1, 1'b0, 8'($urandom_range(32, 126)), ($urandom_range(0, 3) == 0), rd);
      else if (r < 55) xfer(1'b1, 1'b1, 8'($urandom), 1'b0, rd);
      else if (r < 70) xfer(1'b0, 1'b1, 8'($urandom), 1'b0, rd);
      else             xfer(1'b0, 1'b0, rand_cmd(), ($urandom_range(0, 3) == 0), rd);
      post_chk();
      scan_chk($urandom_range(0, 31));
      repeat ($urandom_range(0, 45)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
